// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for rename, with branch
// checkpoints of the allocation (head) pointer for single-cycle mispredict recovery.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_ARCH  = 32,
  parameter int NUM_CKPT  = 4,
  localparam int TAG_W    = $clog2(NUM_PREGS),
  localparam int PTR_W    = TAG_W + 1,
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_preg,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_preg,
  input  logic             ckpt_save,
  input  logic [CKPT_W-1:0] ckpt_tag,
  input  logic             ckpt_restore,
  input  logic [CKPT_W-1:0] restore_tag,
  output logic [PTR_W-1:0] free_count,
  output logic             overflow_err
);

  localparam int               INIT_FREE = NUM_PREGS - NUM_ARCH;
  localparam logic [PTR_W-1:0] INIT_TAIL = PTR_W'(INIT_FREE);
  localparam logic [PTR_W-1:0] MAX_FREE  = PTR_W'(NUM_PREGS - 1);

  logic [TAG_W-1:0] free_ring [NUM_PREGS];
  logic [PTR_W-1:0] ckpt_ptr  [NUM_CKPT];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] head_after_grant;
  logic             grant;
  logic             push_req;
  logic             push_ok;

  // The wrap bit makes the modular difference exact for 0..127 free tags.
  assign free_count       = tail_ptr - head_ptr;
  assign alloc_valid      = (free_count != '0) && !ckpt_restore;
  assign alloc_preg       = free_ring[head_ptr[TAG_W-1:0]];
  assign grant            = alloc_req && alloc_valid;
  assign head_after_grant = head_ptr + PTR_W'(grant);
  assign push_req         = free_valid && (free_preg != '0);
  assign push_ok          = push_req && (free_count != MAX_FREE);

  // NOTE: the ring is reset like any other state because the initial free
  // tags must be present the moment reset asserts, not after a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        free_ring[i] <= (i < INIT_FREE) ? TAG_W'(NUM_ARCH + i) : '0;
      end
    end else if (push_ok) begin
      free_ring[tail_ptr[TAG_W-1:0]] <= free_preg;
    end
  end

  // NOTE: non-blocking assignments throughout, so every update below sees
  // the pre-edge pointers regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr     <= '0;
      tail_ptr     <= INIT_TAIL;
      overflow_err <= 1'b0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_ptr[i] <= '0;
      end
    end else begin
      if (ckpt_restore) begin
        head_ptr <= ckpt_ptr[restore_tag];
      end else begin
        head_ptr <= head_after_grant;
      end

      if (push_ok) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end

      if (push_req && !push_ok) begin
        overflow_err <= 1'b1;
      end

      // A same-cycle grant belongs to the branch itself, so it is captured.
      if (ckpt_save && !ckpt_restore) begin
        ckpt_ptr[ckpt_tag] <= head_after_grant;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios plus a
// randomized run against a position-indexed model of the free list.
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [6:0] alloc_preg;
  logic       free_valid = 1'b0;
  logic [6:0] free_preg = '0;
  logic       ckpt_save = 1'b0;
  logic [1:0] ckpt_tag = '0;
  logic       ckpt_restore = 1'b0;
  logic [1:0] restore_tag = '0;
  logic [7:0] free_count;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .ckpt_save    (ckpt_save),
    .ckpt_tag     (ckpt_tag),
    .ckpt_restore (ckpt_restore),
    .restore_tag  (restore_tag),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  task automatic idle_inputs();
    alloc_req    = 1'b0;
    free_valid   = 1'b0;
    free_preg    = '0;
    ckpt_save    = 1'b0;
    ckpt_tag     = '0;
    ckpt_restore = 1'b0;
    restore_tag  = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (free_count !== 8'd96) begin
      errors++; $display("FAIL reset_free_count: got %0d expected 96", free_count);
    end
    checks++;
    if (alloc_valid !== 1'b1) begin
      errors++; $display("FAIL reset_alloc_valid: got %b expected 1", alloc_valid);
    end
    checks++;
    if (alloc_preg !== 7'd32) begin
      errors++; $display("FAIL reset_alloc_preg: got %0d expected 32", alloc_preg);
    end
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_err);
    end
  endtask

  task automatic test_drain_and_refill();
    apply_reset();
    for (int i = 0; i < 96; i++) begin
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_valid !== 1'b1 || alloc_preg !== 7'(32 + i)) begin
        errors++;
        $display("FAIL drain_seq[%0d]: got valid=%b tag=%0d expected valid=1 tag=%0d",
                 i, alloc_valid, alloc_preg, 32 + i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (alloc_valid !== 1'b0 || free_count !== 8'd0) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b count=%0d expected valid=0 count=0",
               alloc_valid, free_count);
    end
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    checks++;
    if (free_count !== 8'd0) begin
      errors++; $display("FAIL drain_97th_req: got count=%0d expected 0", free_count);
    end
    free_valid = 1'b1;
    free_preg  = 7'd45;
    #1;
    checks++;
    if (alloc_valid !== 1'b0) begin
      errors++; $display("FAIL refill_no_bypass: got valid=%b expected 0", alloc_valid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (alloc_valid !== 1'b1 || alloc_preg !== 7'd45 || free_count !== 8'd1) begin
      errors++;
      $display("FAIL refill_visible: got valid=%b tag=%0d count=%0d expected 1/45/1",
               alloc_valid, alloc_preg, free_count);
    end
  endtask

  task automatic test_checkpoint();
    apply_reset();
    alloc_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ckpt_save = 1'b1;
    ckpt_tag  = 2'd2;
    #1;
    checks++;
    if (alloc_preg !== 7'd34) begin
      errors++; $display("FAIL ckpt_third_alloc: got %0d expected 34", alloc_preg);
    end
    @(negedge clk);
    ckpt_save = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Restore with a competing save and alloc: both must be suppressed.
    ckpt_restore = 1'b1;
    restore_tag  = 2'd2;
    ckpt_save    = 1'b1;
    ckpt_tag     = 2'd1;
    #1;
    checks++;
    if (alloc_valid !== 1'b0) begin
      errors++; $display("FAIL restore_blocks_alloc: got valid=%b expected 0", alloc_valid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (alloc_preg !== 7'd35 || free_count !== 8'd93) begin
      errors++;
      $display("FAIL restore_slot2: got tag=%0d count=%0d expected 35/93", alloc_preg, free_count);
    end
    ckpt_restore = 1'b1;
    restore_tag  = 2'd1;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (alloc_preg !== 7'd32 || free_count !== 8'd96) begin
      errors++;
      $display("FAIL restore_save_dropped: got tag=%0d count=%0d expected 32/96",
               alloc_preg, free_count);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    alloc_req = 1'b1;
    repeat (86) @(negedge clk);
    alloc_req = 1'b0;
    #1;
    checks++;
    if (free_count !== 8'd10 || alloc_preg !== 7'd118) begin
      errors++;
      $display("FAIL simul_setup: got count=%0d tag=%0d expected 10/118", free_count, alloc_preg);
    end
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_preg  = 7'd7;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (free_count !== 8'd10 || alloc_preg !== 7'd119) begin
      errors++;
      $display("FAIL simul_alloc_free: got count=%0d tag=%0d expected 10/119", free_count, alloc_preg);
    end
    alloc_req = 1'b1;
    repeat (9) @(negedge clk);
    alloc_req = 1'b0;
    #1;
    checks++;
    if (free_count !== 8'd1 || alloc_preg !== 7'd7) begin
      errors++;
      $display("FAIL simul_tail_advanced: got count=%0d tag=%0d expected 1/7", free_count, alloc_preg);
    end
    free_valid = 1'b1;
    free_preg  = 7'd0;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (free_count !== 8'd1 || alloc_preg !== 7'd7) begin
      errors++;
      $display("FAIL free_p0_ignored: got count=%0d tag=%0d expected 1/7", free_count, alloc_preg);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int t = 1; t < 32; t++) begin
      free_valid = 1'b1;
      free_preg  = 7'(t);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++;
    if (free_count !== 8'd127 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL fill_127: got count=%0d ovf=%b expected 127/0", free_count, overflow_err);
    end
    free_valid = 1'b1;
    free_preg  = 7'd5;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (free_count !== 8'd127 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_push: got count=%0d ovf=%b expected 127/1", free_count, overflow_err);
    end
  endtask

  // Runs straight after test_overflow so the sticky flag is set going in.
  task automatic test_async_reset();
    alloc_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (free_count !== 8'd96 || alloc_preg !== 7'd32 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d tag=%0d ovf=%b expected 96/32/0",
               free_count, alloc_preg, overflow_err);
    end
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Model: every tag ever entered into the list gets a position in seq;
  // the head is a plain position index, checkpoints are saved positions.
  task automatic test_model(input int n_cycles, input bit pairs);
    int         seq[$];
    int         out_pos[$];
    int         cands[$];
    int         ck_idx[4];
    bit         ck_val[4];
    bit         in_use[128];
    int         head_idx, bound, n_elig, cnt, pick;
    bit         a, fv, rs, sv, push_ok, exp_valid, m_ovf;
    logic [6:0] fp;
    logic [1:0] st, rt;

    apply_reset();
    seq = {};
    out_pos = {};
    for (int t = 32; t < 128; t++) seq.push_back(t);
    for (int t = 0; t < 128; t++) in_use[t] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ck_idx[s] = 0;
      ck_val[s] = 1'b0;
    end
    head_idx = 0;
    m_ovf    = 1'b0;

    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      cnt = seq.size() - head_idx;
      a   = pairs ? 1'b1 : ($urandom_range(0, 99) < 60);

      // Only tags older than every live checkpoint may commit.
      bound = 1 << 30;
      for (int s = 0; s < 4; s++) if (ck_val[s] && ck_idx[s] < bound) bound = ck_idx[s];
      n_elig = 0;
      foreach (out_pos[k]) if (out_pos[k] < bound) n_elig++;

      fv = 1'b0; fp = '0; pick = -1;
      if (n_elig > 0 && (pairs || $urandom_range(0, 1) == 1)) begin
        pick = $urandom_range(0, n_elig - 1);
        fv   = 1'b1;
        fp   = 7'(seq[out_pos[pick]]);
      end else if (!pairs && $urandom_range(0, 19) == 0) begin
        fv = 1'b1;
      end
      push_ok = fv && (fp != 7'd0) && (cnt != 127);

      rs = 1'b0; rt = '0;
      if (!pairs && $urandom_range(0, 99) < 8) begin
        cands = {};
        for (int s = 0; s < 4; s++)
          if (ck_val[s] && ck_idx[s] <= head_idx &&
              seq.size() + int'(push_ok) - ck_idx[s] <= 127) cands.push_back(s);
        if (cands.size() > 0) begin
          rs = 1'b1;
          rt = 2'(cands[$urandom_range(0, cands.size() - 1)]);
        end
      end
      sv = 1'b0; st = '0;
      if (!pairs && !rs && $urandom_range(0, 99) < 15) begin
        sv = 1'b1;
        st = 2'($urandom_range(0, 3));
      end

      alloc_req    = a;
      free_valid   = fv;
      free_preg    = fp;
      ckpt_restore = rs;
      restore_tag  = rt;
      ckpt_save    = sv;
      ckpt_tag     = st;
      #1;

      exp_valid = (cnt != 0) && !rs;
      checks++;
      if (alloc_valid !== exp_valid || free_count !== 8'(cnt) || overflow_err !== m_ovf) begin
        errors++;
        $display("FAIL model_state[%0d]: got valid=%b count=%0d ovf=%b expected %b/%0d/%b",
                 cyc, alloc_valid, free_count, overflow_err, exp_valid, cnt, m_ovf);
      end
      if (exp_valid) begin
        checks++;
        if (alloc_preg !== 7'(seq[head_idx])) begin
          errors++;
          $display("FAIL model_tag[%0d]: got %0d expected %0d", cyc, alloc_preg, seq[head_idx]);
        end
      end

      if (a && exp_valid) begin
        checks++;
        if (in_use[alloc_preg]) begin
          errors++;
          $display("FAIL model_duplicate[%0d]: got tag %0d already allocated expected a free tag",
                   cyc, alloc_preg);
        end
        in_use[seq[head_idx]] = 1'b1;
        out_pos.push_back(head_idx);
        head_idx++;
      end
      if (sv) begin
        ck_idx[st] = head_idx;
        ck_val[st] = 1'b1;
      end
      if (push_ok) begin
        in_use[fp] = 1'b0;
        out_pos.delete(pick);
        seq.push_back(int'(fp));
      end else if (fv && fp != 7'd0) begin
        m_ovf = 1'b1;
      end
      if (rs) begin
        head_idx = ck_idx[rt];
        while (out_pos.size() > 0 && out_pos[$] >= head_idx) begin
          in_use[seq[out_pos[$]]] = 1'b0;
          void'(out_pos.pop_back());
        end
        for (int s = 0; s < 4; s++) if (ck_idx[s] > head_idx) ck_val[s] = 1'b0;
      end
      if (!pairs && $urandom_range(0, 19) == 0) begin
        for (int s = 0; s < 4; s++) ck_val[s] = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_drain_and_refill();
    test_checkpoint();
    test_simultaneous();
    test_overflow();
    test_async_reset();
    test_model(200, 1'b1);
    test_model(600, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
